// File: rtl/counter_pkg.sv
// Shared types and constants for the display-counter run controller.
package counter_pkg;

  // Width of the up/down display counter being controlled.
  localparam int CNT_W = 24;

  // Upper limit of the half-range (non-freerun) mode.
  localparam logic [CNT_W-1:0] HALF_MAX = 24'h7FFFFF;

  // FSM encoding; the numeric values are shown on the LEDs.
  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // True when a half-range run has reached the limit in its current direction.
  // In freerun mode the counter wraps, so there is no limit.
  function automatic logic is_term(input logic             freerun,
                                   input logic             updown,
                                   input logic [CNT_W-1:0] count);
    return !freerun && ((updown && count == HALF_MAX) ||
                        (!updown && count == '0));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stable-level filter, and a
// one-cycle pulse on each accepted press (0->1 of the filtered level).
module btn_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  // The filter counter only needs to reach DEB_CYCLES-1.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the two stages into one.
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has been seen for DEB_CYCLES consecutive
  // cycles; any return to the accepted level restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_cnt <= '0;
      level      <= 1'b0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        level      <= sync2;
        press      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run-control sequencer for the 24-bit up/down display counter: debounces the
// four buttons, runs the clear/idle/run/pause/done machine, holds the
// direction and freerun mode, and paces count steps with a prescaler.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int TICK_DIV   = 1_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_dir,
  input  logic             btn_mode,
  input  logic             btn_clear,
  input  logic [CNT_W-1:0] count,
  output logic             enable1,
  output logic             enable2,
  output logic             updown,
  output logic             freerun,
  output logic             cnt_reset,
  output logic [2:0]       state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t        state_q;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          term;

  logic p_start;
  logic p_dir;
  logic p_mode;
  logic p_clear;

  // Filtered levels are not needed here; only the press pulses drive control.
  logic [3:0] level_unused;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_start),
    .level   (level_unused[0]),
    .press   (p_start)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_dir),
    .level   (level_unused[1]),
    .press   (p_dir)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_mode),
    .level   (level_unused[2]),
    .press   (p_mode)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (btn_clear),
    .level   (level_unused[3]),
    .press   (p_clear)
  );

  assign tick = (tick_cnt == TICK_LAST);
  assign term = is_term(freerun, updown, count);

  // Sequencer, mode toggles and prescaler. The prescaler defaults to zero and
  // only advances on cycles that stay in RUN, so any exit from RUN discards
  // the partial interval and every RUN entry starts a fresh one.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      updown   <= 1'b1;
      freerun  <= 1'b1;
      tick_cnt <= '0;
    end else begin
      tick_cnt <= '0;
      if (p_clear) begin
        state_q <= ST_CLEAR;
      end else begin
        if (state_q != ST_CLEAR) begin
          if (p_dir)  updown  <= ~updown;
          if (p_mode) freerun <= ~freerun;
        end
        case (state_q)
          ST_CLEAR: state_q <= ST_IDLE;
          ST_IDLE:  if (p_start) state_q <= ST_RUN;
          ST_RUN: begin
            if (term) begin
              state_q <= ST_DONE;
            end else if (p_start) begin
              state_q <= ST_PAUSE;
            end else begin
              tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            end
          end
          ST_PAUSE: if (p_start) state_q <= ST_RUN;
          // Restart only if the user has moved off the limit (direction or
          // mode changed); otherwise the run would immediately end again.
          ST_DONE:  if (p_start && !term) state_q <= ST_RUN;
          default:  state_q <= ST_CLEAR;
        endcase
      end
    end
  end

  // Moore decode of the state and prescaler registers; the step is also
  // gated by term so no extra step is issued while the FSM moves to DONE.
  assign state     = state_q;
  assign enable1   = (state_q == ST_CLEAR) || (state_q == ST_RUN);
  assign cnt_reset = (state_q == ST_CLEAR);
  assign enable2   = (state_q == ST_RUN) && tick && !term;

endmodule
